mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter MAX_OUT, default 2: maximum accepted-but-unanswered memory requests (1..4).
REQ-002 Parameter STARVE_LIM, default 4: consecutive data grants allowed while inst_req waits.
REQ-003 clk  in  1  clock; all state updates on posedge clk.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 inst_req  in  1  fetch request (read-only); inst_addr  in  32  fetch address.
REQ-006 inst_addr_ok  out  1  fetch accepted this cycle; inst_data_ok  out  1  fetch data valid; inst_rdata  out  32  fetch data.
REQ-007 inst_cancel  in  1  pipeline flush; discard all outstanding fetch responses.
REQ-008 data_req  in  1  load/store request; data_wr  in  1  1=store; data_wstrb  in  4  byte enables; data_addr  in  32; data_wdata  in  32.
REQ-009 data_addr_ok  out  1  data request accepted; data_data_ok  out  1  load data valid or store complete; data_rdata  out  32.
REQ-010 mem_req  out  1; mem_wr  out  1; mem_wstrb  out  4; mem_addr  out  32; mem_wdata  out  32: shared memory request port.
REQ-011 mem_gnt  in  1  memory accepts mem_req this cycle; mem_rvalid  in  1  in-order response (one per accepted read or write); mem_rdata  in  32.
REQ-012 err_unexp  out  1  sticky: mem_rvalid seen with no outstanding request.

Function
REQ-013 Tag FIFO: MAX_OUT entries, each {src (0=inst, 1=data), discard}; registered count cnt.
REQ-014 Push on mem_req & mem_gnt; pop on mem_rvalid when cnt>0; push and pop in the same cycle leave cnt unchanged.
REQ-015 can_issue = ~reset & (cnt < MAX_OUT), computed from registered cnt only (a same-cycle pop does not enable issue).
REQ-016 Selection: data wins when data_req; inst wins when inst_req & ~data_req, or when inst_req & starve_cnt == STARVE_LIM.
REQ-017 starve_cnt: increments on each data handshake while inst_req=1, saturates at STARVE_LIM, and clears on an inst handshake or when inst_req=0.
REQ-018 mem_req = can_issue & (selected request present); inst is never selected while inst_cancel=1.
REQ-019 mem_wr/wstrb/wdata come from the data port when data is selected; for inst selection they are 0/4'b0000/0; mem_addr follows the selected source.
REQ-020 inst_addr_ok = mem_req & mem_gnt & inst selected; data_addr_ok likewise for data; these two are never asserted together.
REQ-021 Responses, combinational from FIFO head, 0-cycle latency: inst_data_ok = mem_rvalid & cnt>0 & head.src==0 & ~head.discard.
REQ-022 data_data_ok = mem_rvalid & cnt>0 & head.src==1.
REQ-023 inst_rdata and data_rdata both equal mem_rdata.
REQ-024 inst_cancel=1 sets discard on every valid entry with src=0, including an entry whose pop coincides with the cancel (its inst_data_ok is suppressed that cycle).
REQ-025 A discarded entry pops normally on mem_rvalid with no upstream data_ok.
REQ-026 Data entries are never discarded.
REQ-027 mem_rvalid with cnt==0 sets err_unexp, does not change cnt, and asserts no data_ok.
REQ-028 Requesters hold req/addr/wdata stable until their addr_ok; the arbiter holds no request copy.

Reset
REQ-029 On reset: cnt=0, all discard flags 0, starve_cnt=0, err_unexp=0.
REQ-030 While reset=1: mem_req, inst_addr_ok, data_addr_ok, inst_data_ok and data_data_ok are 0.
REQ-031 Reset mid-operation drops all outstanding tags; any mem_rvalid after reset with cnt==0 sets err_unexp.

Verification
REQ-032 Single fetch: inst_req, addr 0x1C000000, mem_gnt=1, mem_rvalid 2 cycles later with 0x02800413 -> inst_addr_ok same cycle, inst_data_ok with inst_rdata=0x02800413, cnt 0->1->0.
REQ-033 Contention: inst_req and data_req (load 0x80, wstrb 0) both high, mem_gnt=1 -> data granted first; inst granted next cycle; responses map in order data then inst.
REQ-034 Starvation: data_req and inst_req held high 6 cycles, mem_gnt=1, immediate responses -> 4 data grants, then 1 inst grant, then data.
REQ-035 Flush: 2 fetches outstanding, inst_cancel pulse, then 2 mem_rvalid -> no inst_data_ok, cnt returns to 0; a new fetch after the cancel returns normally.
REQ-036 Full: MAX_OUT=2, two grants with no response -> mem_req=0 on the third cycle; a pop the same cycle keeps mem_req=0; mem_req=1 the following cycle.
REQ-037 Spurious: mem_rvalid with cnt=0 -> err_unexp=1 and stays 1 until reset.

Source files
------------

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//   Shares one in-order memory request port between an instruction-fetch
//   requester and a load/store requester. Every accepted request pushes a tag
//   {src, discard} into a small FIFO. Each in-order memory response pops the
//   head tag and is routed back to the requester that issued it.
//
//   Data requests normally win the port. The fetch side is forced through
//   after STARVE_LIM consecutive data grants while it waits. A pipeline flush
//   (inst_cancel) marks every outstanding fetch tag as discarded, so those
//   responses are consumed silently.
//
// Parameters
//   MAX_OUT     maximum accepted-but-unanswered memory requests (1..4)
//   STARVE_LIM  consecutive data grants allowed while a fetch waits
//
// Ports
//   clk, reset                    clock, synchronous active-high reset
//   inst_req/inst_addr            fetch request (read-only)
//   inst_addr_ok                  fetch accepted this cycle
//   inst_data_ok/inst_rdata       fetch response
//   inst_cancel                   flush: drop all outstanding fetch responses
//   data_req/wr/wstrb/addr/wdata  load/store request
//   data_addr_ok                  load/store accepted this cycle
//   data_data_ok/data_rdata       load data valid or store complete
//   mem_req/wr/wstrb/addr/wdata   shared memory request port
//   mem_gnt                       memory accepts mem_req this cycle
//   mem_rvalid/mem_rdata          in-order memory response
//   err_unexp                     sticky: response seen with nothing outstanding
// -----------------------------------------------------------------------------
module mem_arbiter #(
  parameter int MAX_OUT    = 2,
  parameter int STARVE_LIM = 4
) (
  input  logic        clk,
  input  logic        reset,
  // instruction fetch port
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  input  logic        inst_cancel,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  // load/store port
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  // shared memory port
  output logic        mem_req,
  output logic        mem_wr,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  // status
  output logic        err_unexp
);

  localparam int PW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
  localparam int CW = $clog2(MAX_OUT + 1);
  localparam int SW = (STARVE_LIM > 0) ? $clog2(STARVE_LIM + 1) : 1;

  // Tag FIFO state
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [PW-1:0]      head_q, head_d;
  logic [PW-1:0]      tail_q, tail_d;
  logic [MAX_OUT-1:0] src_q, src_d;     // 0 = fetch, 1 = load/store
  logic [MAX_OUT-1:0] disc_q, disc_d;   // response to be dropped silently
  logic [MAX_OUT-1:0] valid;            // entry currently holds a live tag

  // Arbitration state
  logic [SW-1:0]      starve_q, starve_d;
  logic               err_q, err_d;

  // Combinational control
  logic can_issue;
  logic inst_ok;
  logic starved;
  logic sel_inst;
  logic sel_data;
  logic push;
  logic pop;
  logic has_head;
  logic head_src;
  logic head_disc;
  logic inst_hs;
  logic data_hs;

  // Circular pointer advance for a FIFO that need not be a power of two deep.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == PW'(MAX_OUT - 1)) begin
      return '0;
    end
    return p + PW'(1);
  endfunction

  // Saturating increment of the starvation counter.
  function automatic logic [SW-1:0] sat_inc(input logic [SW-1:0] v);
    if (v == SW'(STARVE_LIM)) begin
      return v;
    end
    return v + SW'(1);
  endfunction

  // ---------------------------------------------------------------------------
  // Arbitration and request path
  // ---------------------------------------------------------------------------
  // Issue is gated by the registered count only; a response arriving in the
  // same cycle frees a slot for the next cycle, not this one.
  assign can_issue = ~reset & (cnt_q < CW'(MAX_OUT));

  // A flushing pipeline must not issue a fetch it would immediately discard.
  assign inst_ok   = inst_req & ~inst_cancel;
  assign starved   = (starve_q == SW'(STARVE_LIM));
  assign sel_inst  = inst_ok & (~data_req | starved);
  assign sel_data  = data_req & ~sel_inst;

  assign mem_req   = can_issue & (sel_inst | sel_data);
  assign mem_wr    = sel_data & data_wr;
  assign mem_wstrb = sel_data ? data_wstrb : 4'b0000;
  assign mem_wdata = sel_data ? data_wdata : 32'h0000_0000;
  assign mem_addr  = sel_data ? data_addr  : inst_addr;

  assign push      = mem_req & mem_gnt;
  assign inst_hs   = push & sel_inst;
  assign data_hs   = push & sel_data;

  assign inst_addr_ok = inst_hs;
  assign data_addr_ok = data_hs;

  // ---------------------------------------------------------------------------
  // Response path (zero latency from the FIFO head)
  // ---------------------------------------------------------------------------
  assign has_head  = (cnt_q != '0);
  assign pop       = mem_rvalid & has_head & ~reset;
  assign head_src  = src_q[head_q];
  assign head_disc = disc_q[head_q];

  // A cancel landing on the same cycle as a fetch response also drops it.
  assign inst_data_ok = pop & ~head_src & ~head_disc & ~inst_cancel;
  assign data_data_ok = pop & head_src;
  assign inst_rdata   = mem_rdata;
  assign data_rdata   = mem_rdata;
  assign err_unexp    = err_q;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    int off;
    off   = 0;
    valid = '0;
    // An entry is live when its distance from head is below the count.
    for (int i = 0; i < MAX_OUT; i++) begin
      off = i - int'(head_q);
      if (off < 0) begin
        off = off + MAX_OUT;
      end
      valid[i] = (off < int'(cnt_q));
    end
  end

  always_comb begin
    cnt_d    = cnt_q;
    head_d   = head_q;
    tail_d   = tail_q;
    src_d    = src_q;
    disc_d   = disc_q;
    starve_d = starve_q;
    err_d    = err_q;

    if (push && !pop) begin
      cnt_d = cnt_q + CW'(1);
    end else if (pop && !push) begin
      cnt_d = cnt_q - CW'(1);
    end

    if (pop) begin
      head_d = ptr_inc(head_q);
    end

    // Flush marks every live fetch tag, including the one popping now.
    if (inst_cancel) begin
      for (int i = 0; i < MAX_OUT; i++) begin
        if (valid[i] && !src_q[i]) begin
          disc_d[i] = 1'b1;
        end
      end
    end

    if (push) begin
      src_d[tail_q]  = sel_data;
      disc_d[tail_q] = 1'b0;
      tail_d         = ptr_inc(tail_q);
    end

    if (!inst_req || inst_hs) begin
      starve_d = '0;
    end else if (data_hs) begin
      starve_d = sat_inc(starve_q);
    end

    if (mem_rvalid && !has_head) begin
      err_d = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q    <= '0;
      head_q   <= '0;
      tail_q   <= '0;
      disc_q   <= '0;
      starve_q <= '0;
      err_q    <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      head_q   <= head_d;
      tail_q   <= tail_d;
      disc_q   <= disc_d;
      starve_q <= starve_d;
      err_q    <= err_d;
    end
  end

  // The source flag is only meaningful while its entry is live, so it needs
  // no reset.
  always_ff @(posedge clk) begin
    src_q <= src_d;
  end

endmodule
